// File: rtl/mxv_pkg.sv
// Shared types and constants for the MXV frame parser.
// Contents:
//   parser_state_t   parser FSM states
//   field_t          which frame field the next received byte belongs to
//   ERR_*            err_code values reported on a failed frame
//   DEFAULT_END_BYTE terminator byte expected at the end of every frame
package mxv_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WAIT   = 3'd1,
    ST_CLEAR  = 3'd2,
    ST_DECODE = 3'd3,
    ST_DONE   = 3'd4,
    ST_ERROR  = 3'd5
  } parser_state_t;

  typedef enum logic [1:0] {
    F_LEN  = 2'd0,
    F_CMD  = 2'd1,
    F_DATA = 2'd2,
    F_END  = 2'd3
  } field_t;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_LEN  = 2'b01;
  localparam logic [1:0] ERR_END  = 2'b10;
  localparam logic [1:0] ERR_TMO  = 2'b11;

  localparam logic [7:0] DEFAULT_END_BYTE = 8'hEF;

endpackage

// File: rtl/mxv_frame_parser_if.sv
// Byte-in / data-out bus between the UART RX flag, the frame parser and the
// matrix/vector buffer.
// Signals:
//   rx_int    RX byte-ready level flag, held until clear_rx
//   rx_data   received byte, valid while rx_int=1
//   clear_rx  one-cycle acknowledge of the captured byte
//   wr_en     data-byte write strobe into the buffer
//   wr_addr   0-based data index
//   wr_data   data byte
// Modports: master = parser side, slave = RX/buffer side.
interface mxv_frame_parser_if #(
  parameter int ADDR_W = 4
);

  logic              rx_int;
  logic [7:0]        rx_data;
  logic              clear_rx;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;

  modport master (
    input  rx_int, rx_data,
    output clear_rx, wr_en, wr_addr, wr_data
  );

  modport slave (
    output rx_int, rx_data,
    input  clear_rx, wr_en, wr_addr, wr_data
  );

endinterface

// File: rtl/mxv_timeout_ctr.sv
// Saturating inter-byte timeout counter.
// Ports:
//   clk, reset  clock, async active-low reset
//   clear       synchronous zero (takes priority over enable)
//   enable      count one per cycle
//   expired     count has reached TIMEOUT_CYC-1
module mxv_timeout_ctr #(
  parameter int TIMEOUT_CYC = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] count_r;

  // Count up and hold at LAST so a stalled frame cannot wrap back to zero
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_r <= '0;
    end else if (clear) begin
      count_r <= '0;
    end else if (enable && (count_r != LAST)) begin
      count_r <= count_r + CNT_W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign expired = (count_r == LAST);

endmodule

// File: rtl/mxv_frame_parser.sv
// MXV frame body parser. Runs while locked is high and parses
// LEN, CMD, LEN-1 data bytes, END from the UART RX byte flag, writing the
// data bytes to the matrix/vector buffer and latching CMD.
// Ports:
//   clk, reset  clock, async active-low reset
//   bus         RX flag/ack and buffer write bus (master side)
//   locked      frame lock from the start-field unit
//   cmd         last accepted CMD, held between frames
//   cmd_valid   one-cycle pulse, frame accepted
//   frame_done  one-cycle pulse, good frame
//   frame_err   one-cycle pulse, bad frame
//   err_code    reason of the last failure, cleared when a frame starts
//   unlock      one-cycle pulse re-arming the start-field unit
//   busy        parser is not idle
module mxv_frame_parser
  import mxv_pkg::*;
#(
  parameter int         MAX_LEN     = 16,
  parameter int         ADDR_W      = 4,
  parameter logic [7:0] END_BYTE    = DEFAULT_END_BYTE,
  parameter int         TIMEOUT_CYC = 500000
) (
  input  logic               clk,
  input  logic               reset,
  mxv_frame_parser_if.master bus,
  input  logic               locked,
  output logic [7:0]         cmd,
  output logic               cmd_valid,
  output logic               frame_done,
  output logic               frame_err,
  output logic [1:0]         err_code,
  output logic               unlock,
  output logic               busy
);

  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  parser_state_t     state_r;
  field_t            field_r;
  logic [7:0]        byte_r;
  logic [7:0]        rem_r;
  logic [7:0]        cmd_q_r;
  logic [7:0]        cmd_r;
  logic [ADDR_W-1:0] idx_r;
  logic [1:0]        err_code_r;
  logic              clear_rx_r;
  logic              cmd_valid_r;
  logic              frame_done_r;
  logic              frame_err_r;
  logic              unlock_r;
  logic              tmo_clear_s;
  logic              tmo_enable_s;
  logic              tmo_expired_s;
  logic              wr_en_s;

  // The inter-byte budget is measured from the capture edge, so the
  // counter keeps running through CLEAR and DECODE and only WAIT acts on it.
  assign tmo_clear_s  = (state_r == ST_IDLE) || ((state_r == ST_WAIT) && bus.rx_int);
  assign tmo_enable_s = (state_r != ST_IDLE);

  mxv_timeout_ctr #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timeout_ctr (
    .clk     (clk),
    .reset   (reset),
    .clear   (tmo_clear_s),
    .enable  (tmo_enable_s),
    .expired (tmo_expired_s)
  );

  // Data writes come straight from the decode cycle so they still issue
  // when locked drops in that same cycle.
  assign wr_en_s      = (state_r == ST_DECODE) && (field_r == F_DATA);
  assign bus.wr_en    = wr_en_s;
  assign bus.wr_addr  = idx_r;
  assign bus.wr_data  = byte_r;
  assign bus.clear_rx = clear_rx_r;

  assign cmd        = cmd_r;
  assign cmd_valid  = cmd_valid_r;
  assign frame_done = frame_done_r;
  assign frame_err  = frame_err_r;
  assign err_code   = err_code_r;
  assign unlock     = unlock_r;
  assign busy       = (state_r != ST_IDLE);

  // Frame sequencing FSM; pulses are set on the transition into the state they belong to
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= ST_IDLE;
      field_r      <= F_LEN;
      byte_r       <= 8'h00;
      rem_r        <= 8'h00;
      cmd_q_r      <= 8'h00;
      cmd_r        <= 8'h00;
      idx_r        <= '0;
      err_code_r   <= ERR_NONE;
      clear_rx_r   <= 1'b0;
      cmd_valid_r  <= 1'b0;
      frame_done_r <= 1'b0;
      frame_err_r  <= 1'b0;
      unlock_r     <= 1'b0;
    end else begin
      clear_rx_r   <= 1'b0;
      cmd_valid_r  <= 1'b0;
      frame_done_r <= 1'b0;
      frame_err_r  <= 1'b0;
      unlock_r     <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (locked) begin
            state_r    <= ST_WAIT;
            field_r    <= F_LEN;
            idx_r      <= '0;
            rem_r      <= 8'h00;
            err_code_r <= ERR_NONE;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          if (!locked) begin
            state_r <= ST_IDLE;
          end else if (bus.rx_int) begin
            byte_r     <= bus.rx_data;
            clear_rx_r <= 1'b1;
            state_r    <= ST_CLEAR;
          end else if (tmo_expired_s) begin
            err_code_r  <= ERR_TMO;
            frame_err_r <= 1'b1;
            unlock_r    <= 1'b1;
            state_r     <= ST_ERROR;
          end else begin
            state_r <= ST_WAIT;
          end
        end
        ST_CLEAR: begin
          state_r <= locked ? ST_DECODE : ST_IDLE;
        end
        ST_DECODE: begin
          if (!locked) begin
            state_r <= ST_IDLE;
          end else begin
            state_r <= ST_WAIT;
            case (field_r)
              F_LEN: begin
                if ((byte_r == 8'h00) || (byte_r > MAX_LEN_B)) begin
                  err_code_r  <= ERR_LEN;
                  frame_err_r <= 1'b1;
                  unlock_r    <= 1'b1;
                  state_r     <= ST_ERROR;
                end else begin
                  rem_r   <= byte_r;
                  field_r <= F_CMD;
                end
              end
              F_CMD: begin
                cmd_q_r <= byte_r;
                rem_r   <= rem_r - 8'd1;
                // rem of one means only CMD was counted: no data bytes follow
                field_r <= (rem_r == 8'd1) ? F_END : F_DATA;
              end
              F_DATA: begin
                idx_r   <= idx_r + ADDR_W'(1);
                rem_r   <= rem_r - 8'd1;
                field_r <= (rem_r == 8'd1) ? F_END : F_DATA;
              end
              F_END: begin
                if (byte_r == END_BYTE) begin
                  // cmd updates together with cmd_valid so both are seen in one cycle
                  cmd_r        <= cmd_q_r;
                  cmd_valid_r  <= 1'b1;
                  frame_done_r <= 1'b1;
                  unlock_r     <= 1'b1;
                  state_r      <= ST_DONE;
                end else begin
                  err_code_r  <= ERR_END;
                  frame_err_r <= 1'b1;
                  unlock_r    <= 1'b1;
                  state_r     <= ST_ERROR;
                end
              end
              default: begin
                field_r <= F_LEN;
              end
            endcase
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
        end
        ST_ERROR: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
